uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter producing 8N1 frames (one start bit, eight data bits LSB first, one stop bit) at a fixed rate of `CLKS_PER_BIT` clocks per bit. It is the transmit-side counterpart of the UART receiver in the same serial block, sharing its bit timing and framing, so a loopback of `o_tx_serial` into the receiver reproduces every byte sent. A small input FIFO decouples the byte producer from line rate and allows back-to-back frames without producer stalls.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per serial bit; must be ≥ 2; counter is 16 bits wide.
- `FIFO_DEPTH`, 4: input FIFO entries; must be a power of 2 and ≥ 2.
- `i_clk` input 1: sole clock; all logic is on the rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_tx_dv` input 1: byte-valid strobe from the producer.
- `i_tx_byte` input 8: byte to send; sampled when `i_tx_dv && o_tx_ready`.
- `o_tx_ready` output 1: FIFO not full, so a write this cycle is accepted.
- `o_tx_serial` output 1: serial line, registered; idles high.
- `o_tx_active` output 1: high while a frame (start through stop bit) is on the line.
- `o_tx_done` output 1: one-cycle pulse after each frame's stop bit completes.

## Operation
- FIFO:
  - Write occurs on an edge where `i_tx_dv && o_tx_ready`.
  - `o_tx_ready` = (count < `FIFO_DEPTH`) and is derived from the registered count.
  - A write attempted while full is dropped silently; no state changes.
  - Simultaneous write and pop leaves the count unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- FSM states are IDLE, START_BIT, DATA_BITS, STOP_BIT and CLEANUP.
- IDLE:
  - Line is high and the clock counter and bit index are 0.
  - If the FIFO is non-empty, pop the head into the shift register and go to START_BIT.
- START_BIT:
  - Line is low.
  - Count 0..`CLKS_PER_BIT`-1, then clear the counter and go to DATA_BITS.
- DATA_BITS:
  - Line carries `data[bit_index]`, with `bit_index` running 0..7 (LSB first).
  - At each terminal count, clear the counter and increment the index.
  - After bit 7's terminal count, reset the index to 0 and go to STOP_BIT.
- STOP_BIT:
  - Line is high.
  - At terminal count, clear the counter and go to CLEANUP.
- CLEANUP:
  - Line is high and `o_tx_done` = 1 for this single cycle.
  - Next state is always IDLE.
- `o_tx_active` = 1 exactly in START_BIT, DATA_BITS and STOP_BIT.
- Producer writes during a frame are accepted normally while the FIFO has space.
- Reset mid-frame:
  - The FIFO is flushed and the FSM returns to IDLE.
  - `o_tx_serial` is 1 from the cycle after the reset edge; the partial frame is abandoned and no `o_tx_done` pulse is issued.
  - Writes presented during reset are dropped.
- Unreachable state encodings return to IDLE with the line high.

## Timing
- Reset values:
  - `o_tx_serial`=1, `o_tx_active`=0, `o_tx_done`=0, `o_tx_ready`=1.
  - FIFO empty, FSM in IDLE.
- Latency with the FIFO empty and the FSM in IDLE:
  - Byte written at edge N.
  - Pop occurs at edge N+1.
  - `o_tx_serial` goes low and `o_tx_active` goes high after edge N+2.
- Frame:
  - Start, each data bit and stop are each exactly `CLKS_PER_BIT` cycles.
  - `o_tx_active` is high for 10·`CLKS_PER_BIT` cycles.
- `o_tx_done` is high for the one cycle immediately following the last stop-bit cycle.
- Back-to-back frames:
  - Frame period is 10·`CLKS_PER_BIT` + 2 cycles.
  - The 2 cycles are CLEANUP plus IDLE, with the line high in both.
- `o_tx_ready` deasserts the cycle after the write that fills the FIFO. It reasserts the cycle after the pop that frees an entry.

## Test plan
- Reset, then drive no traffic for 100 cycles with `CLKS_PER_BIT`=4:
  - `o_tx_serial`=1, `o_tx_active`=0, `o_tx_done`=0 and `o_tx_ready`=1 for all 100 cycles.
- Single byte 0xA5 with `CLKS_PER_BIT`=4:
  - Line is low 4 cycles.
  - Data bits are 1,0,1,0,0,1,0,1, each 4 cycles.
  - Stop is high 4 cycles.
  - `o_tx_done` pulses once; start falls 2 edges after the write.
  - Looped into the receiver, it yields 0xA5.
- Burst of 0x00, 0xFF, 0x55, 0x81 in consecutive cycles:
  - All 4 writes are accepted.
  - Frames are contiguous with a 42-cycle period and 4 `o_tx_done` pulses, with bytes in order.
- Overflow with `FIFO_DEPTH`=4:
  - Write 6 bytes in consecutive cycles.
  - The first pop frees a slot, so 5 are accepted; `o_tx_ready` is low for at least one cycle.
  - The 6th write, attempted while full, is dropped, and exactly 5 frames are sent.
- Reset asserted mid-frame (during data bit 3) with 2 bytes queued:
  - Line is high the next cycle and `o_tx_active`=0.
  - No `o_tx_done` is issued and no further frames are sent.
  - `o_tx_ready`=1.
- Write presented on the same edge as a pop while the FIFO holds 3 entries:
  - Count stays at 3 and the byte order is preserved on the line.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with a small input FIFO
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        CLEANUP   = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   clk_cnt, clk_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic          line_nxt, active_nxt, done_nxt;
    logic          terminal;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;
    logic          fifo_wr, fifo_pop;

    assign o_tx_ready = fifo_count < (AW+1)'(FIFO_DEPTH);
    assign fifo_wr    = i_tx_dv && o_tx_ready;
    assign terminal   = clk_cnt == 16'(CLKS_PER_BIT - 1);

    always_ff @(posedge i_clk) begin
        if (fifo_wr && !i_rst) begin
            fifo_mem[wr_ptr] <= i_tx_byte;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Outputs are registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            o_tx_serial <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            state       <= state_nxt;
            clk_cnt     <= clk_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shift_reg   <= shift_nxt;
            o_tx_serial <= line_nxt;
            o_tx_active <= active_nxt;
            o_tx_done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_reg;
        fifo_pop    = 1'b0;
        line_nxt    = 1'b1;
        active_nxt  = 1'b0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
                if (fifo_count != '0) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_mem[rd_ptr];
                    state_nxt = START_BIT;
                end
            end
            START_BIT: begin
                line_nxt   = 1'b0;
                active_nxt = 1'b1;
                if (terminal) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = DATA_BITS;
                end else begin
                    clk_cnt_nxt = clk_cnt + 16'd1;
                end
            end
            DATA_BITS: begin
                line_nxt   = shift_reg[bit_idx];
                active_nxt = 1'b1;
                if (terminal) begin
                    clk_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_nxt = '0;
                        state_nxt   = STOP_BIT;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 16'd1;
                end
            end
            STOP_BIT: begin
                active_nxt = 1'b1;
                if (terminal) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = CLEANUP;
                end else begin
                    clk_cnt_nxt = clk_cnt + 16'd1;
                end
            end
            CLEANUP: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
                state_nxt   = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_tx_dv = 1'b0;
    logic [7:0] i_tx_byte = 8'h00;
    logic       o_tx_ready, o_tx_serial, o_tx_active, o_tx_done;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int cyc = 0;
    int done_cnt = 0;

    logic [7:0] got [6];
    int         ts  [6];
    int         a5_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    logic [7:0] burst [4] = '{8'h00, 8'hFF, 8'h55, 8'h81};
    logic [7:0] ovf   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] ordr  [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tx_dv     (i_tx_dv),
        .i_tx_byte   (i_tx_byte),
        .o_tx_ready  (o_tx_ready),
        .o_tx_serial (o_tx_serial),
        .o_tx_active (o_tx_active),
        .o_tx_done   (o_tx_done)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;
    always @(negedge i_clk) if (o_tx_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference receiver: finds the start edge, then samples each bit mid-cell.
    task automatic rx_byte(output logic [7:0] b, output int t_start);
        int n = 0;
        b = 'x;
        t_start = -1;
        while (o_tx_serial !== 1'b0 && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (o_tx_serial === 1'b0) begin
            t_start = cyc;
            repeat (CPB / 2) @(negedge i_clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge i_clk);
                b[i] = o_tx_serial;
            end
            repeat (CPB) @(negedge i_clk);
            if (o_tx_serial !== 1'b1) b = 'x;
        end
    endtask

    initial begin
        int d0, lows, acc, saw_low, k;

        repeat (3) @(negedge i_clk);
        check("reset_outputs", {o_tx_serial, o_tx_active, o_tx_done, o_tx_ready}, 4'b1001);
        i_rst = 1'b0;

        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if ({o_tx_serial, o_tx_active, o_tx_done, o_tx_ready} !== 4'b1001) lows++;
        end
        check("idle_100_cycles_bad", lows, 0);

        // Single byte 0xA5, cycle-exact line check with the receiver in parallel.
        d0 = done_cnt;
        i_tx_dv = 1'b1;
        i_tx_byte = 8'hA5;
        fork
            begin
                @(negedge i_clk);
                i_tx_dv = 1'b0;
                check("a5_line_after_n", o_tx_serial, 1'b1);
                @(negedge i_clk);
                check("a5_line_after_n1", {o_tx_serial, o_tx_active}, 2'b10);
                lows = 0;
                for (int c = 0; c < 40; c++) begin
                    @(negedge i_clk);
                    if (o_tx_active !== 1'b1) lows++;
                    if (c < 4) begin
                        if (o_tx_serial !== 1'b0) lows++;
                    end else if (c >= 36) begin
                        if (o_tx_serial !== 1'b1) lows++;
                    end else begin
                        if (o_tx_serial !== 1'(a5_bits[(c - 4) / 4])) lows++;
                    end
                end
                check("a5_frame_cells_bad", lows, 0);
                @(negedge i_clk);
                check("a5_done_pulse", {o_tx_done, o_tx_active, o_tx_serial}, 3'b101);
                @(negedge i_clk);
                check("a5_done_cleared", o_tx_done, 1'b0);
            end
            rx_byte(got[0], ts[0]);
        join
        check("a5_loopback", got[0], 8'hA5);
        repeat (5) @(negedge i_clk);
        check("a5_done_count", done_cnt - d0, 1);

        // Burst of four back-to-back writes.
        d0 = done_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    i_tx_dv = 1'b1;
                    i_tx_byte = burst[i];
                    check("burst_ready", o_tx_ready, 1'b1);
                    @(negedge i_clk);
                end
                i_tx_dv = 1'b0;
            end
            for (int i = 0; i < 4; i++) rx_byte(got[i], ts[i]);
        join
        repeat (10) @(negedge i_clk);
        for (int i = 0; i < 4; i++) check("burst_byte", got[i], burst[i]);
        for (int i = 1; i < 4; i++) check("burst_period", ts[i] - ts[i-1], 42);
        check("burst_done_count", done_cnt - d0, 4);

        // Overflow: six writes into a depth-4 FIFO.
        d0 = done_cnt;
        acc = 0;
        saw_low = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    i_tx_dv = 1'b1;
                    i_tx_byte = ovf[i];
                    if (o_tx_ready === 1'b1) acc++;
                    else saw_low = 1;
                    @(negedge i_clk);
                end
                i_tx_dv = 1'b0;
            end
            for (int i = 0; i < 5; i++) rx_byte(got[i], ts[i]);
        join
        check("ovf_accepted", acc, 5);
        check("ovf_ready_low_seen", saw_low, 1);
        for (int i = 0; i < 5; i++) check("ovf_byte", got[i], ovf[i]);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge i_clk);
            if (o_tx_serial !== 1'b1) lows++;
        end
        check("ovf_no_sixth_frame", lows, 0);
        check("ovf_done_count", done_cnt - d0, 5);

        // Reset during data bit 3 with two bytes queued.
        for (int i = 0; i < 3; i++) begin
            i_tx_dv = 1'b1;
            i_tx_byte = 8'h00 + 8'(i * 8'h12);
            @(negedge i_clk);
        end
        i_tx_dv = 1'b0;
        k = 0;
        while (o_tx_serial !== 1'b0 && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        check("rst_frame_started", o_tx_serial, 1'b0);
        repeat (17) @(negedge i_clk);
        check("rst_mid_bit3", {o_tx_active, o_tx_serial}, 2'b10);
        d0 = done_cnt;
        i_rst = 1'b1;
        i_tx_dv = 1'b1;
        i_tx_byte = 8'h77;
        @(negedge i_clk);
        check("rst_after_edge", {o_tx_serial, o_tx_active, o_tx_done, o_tx_ready}, 4'b1001);
        i_rst = 1'b0;
        i_tx_dv = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (o_tx_serial !== 1'b1 || o_tx_active !== 1'b0) lows++;
        end
        check("rst_no_more_frames", lows, 0);
        check("rst_no_done", done_cnt - d0, 0);

        // Write coinciding with a pop while three entries are queued.
        i_tx_dv = 1'b1;
        i_tx_byte = ordr[0];
        fork
            begin
                for (int i = 1; i < 4; i++) begin
                    @(negedge i_clk);
                    i_tx_byte = ordr[i];
                end
                @(negedge i_clk);
                i_tx_dv = 1'b0;
                check("same_edge_count_before", dut.fifo_count, 3);
                repeat (39) @(negedge i_clk);
                check("same_edge_count_pre_pop", dut.fifo_count, 3);
                i_tx_dv = 1'b1;
                i_tx_byte = ordr[4];
                @(negedge i_clk);
                i_tx_dv = 1'b0;
                check("same_edge_count_after", dut.fifo_count, 3);
            end
            for (int i = 0; i < 5; i++) rx_byte(got[i], ts[i]);
        join
        for (int i = 0; i < 5; i++) check("same_edge_order", got[i], ordr[i]);

        repeat (10) @(negedge i_clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
